// File: rtl/crc_serial_codec_pkg.sv
// Shared types and constants for the serial CRC codec.
// Holds the FSM state enum and well-known generator polynomials.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [6:0]  CRC7_POLY        = 7'h09;
    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;

    // Bit-counter width able to hold 0..w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// One bit of a non-reflected CRC shift register.
// Pure combinational; reused by serial and parallel codecs.
module crc_lfsr_step
    import crc_pkg::*;
#(
    parameter int          CRC_W = 7,
    parameter logic [31:0] POLY  = 32'(CRC7_POLY)
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic             din,
    output logic [CRC_W-1:0] crc_out
);

    localparam logic [CRC_W-1:0] POLY_M = POLY[CRC_W-1:0];

    logic fb;

    // Shift left; fold the polynomial in when the feedback bit is set.
    always_comb begin
        fb      = crc_in[CRC_W-1] ^ din;
        crc_out = {crc_in[CRC_W-2:0], 1'b0} ^ (fb ? POLY_M : '0);
    end

endmodule

// File: rtl/crc_serial_codec.sv
// Bit-serial CRC generator/checker with valid/ready on both sides.
// One payload word per handshake, shifted MSB-first, one bit per clock.
module crc_serial_codec
    import crc_pkg::*;
#(
    parameter int          DATA_W = 16,
    parameter int          CRC_W  = 7,
    parameter logic [31:0] POLY   = 32'(CRC7_POLY),
    parameter logic [31:0] INIT   = 32'h0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [CRC_W-1:0]        in_crc,
    input  logic                    in_check,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W+CRC_W-1:0] out_code,
    output logic [CRC_W-1:0]        out_crc,
    output logic                    out_err,
    output logic                    busy
);

    localparam int                 CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CRC_W-1:0]   INIT_M   = INIT[CRC_W-1:0];

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_W-1:0]       data_q;
    logic [DATA_W-1:0]       sh_q;
    logic [CRC_W-1:0]        crc_q;
    logic [CRC_W-1:0]        ref_q;
    logic                    chk_q;
    logic [DATA_W+CRC_W-1:0] code_q;
    logic [CRC_W-1:0]        ocrc_q;
    logic                    err_q;

    logic [CRC_W-1:0]        crc_nxt;
    logic                    accept;
    logic                    last;

    crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .crc_in  (crc_q),
        .din     (sh_q[DATA_W-1]),
        .crc_out (crc_nxt)
    );

    assign accept = in_valid && (state_q == IDLE);
    assign last   = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: accept, shift DATA_W bits, hold until drained.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = SHIFT;
            SHIFT:   if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // Datapath: latch word on accept, step the CRC, capture result.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            data_q <= '0;
            sh_q   <= '0;
            crc_q  <= '0;
            ref_q  <= '0;
            chk_q  <= 1'b0;
            code_q <= '0;
            ocrc_q <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            cnt_q  <= '0;
            data_q <= in_data;
            sh_q   <= in_data;
            crc_q  <= INIT_M;
            ref_q  <= in_crc;
            chk_q  <= in_check;
        end else if (state_q == SHIFT) begin
            crc_q <= crc_nxt;
            sh_q  <= sh_q << 1;
            if (last) begin
                code_q <= {data_q, crc_nxt};
                ocrc_q <= crc_nxt;
                err_q  <= chk_q && (crc_nxt != ref_q);
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign out_code = code_q;
    assign out_crc  = ocrc_q;
    assign out_err  = err_q;

endmodule

// File: tb/tb_crc_serial_codec.sv
// Directed bench for crc_serial_codec: 16-bit and 40-bit payloads.
// Expected CRCs are hand-derived remainders mod x^7+x^3+1.
module tb_crc_serial_codec;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_check;
    logic [15:0] in_data;
    logic [6:0]  in_crc;
    logic        out_valid, out_ready, out_err, busy;
    logic [22:0] out_code;
    logic [6:0]  out_crc;

    logic        b_valid, b_ready, b_check;
    logic [39:0] b_data;
    logic [6:0]  b_crc_i;
    logic        b_ovalid, b_oready, b_err, b_busy;
    logic [46:0] b_code;
    logic [6:0]  b_crc;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crc_serial_codec u16 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_crc(in_crc), .in_check(in_check),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_crc(out_crc),
        .out_err(out_err), .busy(busy)
    );

    crc_serial_codec #(.DATA_W(40)) u40 (
        .clk(clk), .reset(reset),
        .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .in_crc(b_crc_i), .in_check(b_check),
        .out_valid(b_ovalid), .out_ready(b_oready),
        .out_code(b_code), .out_crc(b_crc),
        .out_err(b_err), .busy(b_busy)
    );

    typedef struct {
        logic [15:0] d;
        logic        chk;
        logic [6:0]  crc;
        logic [6:0]  e_crc;
        logic [22:0] e_code;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [39:0] d;
        logic [6:0]  e_crc;
    } vec40_t;

    vec_t   v[6];
    vec40_t w[3];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Push one word through the 16-bit DUT; returns results and latency.
    task automatic send16(input logic [15:0] d, input logic c,
                          input logic [6:0] rc,
                          output logic [6:0] r_crc,
                          output logic [22:0] r_code,
                          output logic r_err, output int lat);
        int j;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_check = c;
        in_crc   = rc;
        j = 0;
        while (!in_ready && j < 100) begin
            @(negedge clk);
            j++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        j = 0;
        while (!out_valid && j < 100) begin
            @(negedge clk);
            j++;
        end
        r_crc  = out_crc;
        r_code = out_code;
        r_err  = out_err;
        lat    = j + 1;
    endtask

    initial begin
        logic [6:0]  r_crc;
        logic [22:0] r_code;
        logic        r_err;
        int          lat;
        int          acc[4];
        logic [15:0] bw[4];
        logic [6:0]  be[4];
        logic        seen;
        int          j;

        v[0] = '{16'h0001, 1'b0, 7'h00, 7'h09, 23'h000089, 1'b0};
        v[1] = '{16'h0000, 1'b0, 7'h00, 7'h00, 23'h000000, 1'b0};
        v[2] = '{16'h0001, 1'b1, 7'h09, 7'h09, 23'h000089, 1'b0};
        v[3] = '{16'h0001, 1'b1, 7'h08, 7'h09, 23'h000089, 1'b1};
        v[4] = '{16'h8000, 1'b0, 7'h00, 7'h53, 23'h400053, 1'b0};
        v[5] = '{16'h0003, 1'b1, 7'h1B, 7'h1B, 23'h00019B, 1'b0};

        w[0] = '{40'h4000000000, 7'h4A};
        w[1] = '{40'h5100000000, 7'h2A};
        w[2] = '{40'h48000001AA, 7'h43};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_crc    = '0;
        in_check  = 1'b0;
        out_ready = 1'b1;
        b_valid   = 1'b0;
        b_data    = '0;
        b_crc_i   = '0;
        b_check   = 1'b0;
        b_oready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_code",  64'(out_code),  64'd0);
        chk("rst_out_crc",   64'(out_crc),   64'd0);
        chk("rst_out_err",   64'(out_err),   64'd0);
        chk("rst_busy",      64'(busy),      64'd0);

        // Table-driven vectors, out_ready held high.
        for (int i = 0; i < 6; i++) begin
            send16(v[i].d, v[i].chk, v[i].crc, r_crc, r_code, r_err, lat);
            chk($sformatf("vec%0d_crc", i),  64'(r_crc),  64'(v[i].e_crc));
            chk($sformatf("vec%0d_code", i), 64'(r_code), 64'(v[i].e_code));
            chk($sformatf("vec%0d_err", i),  64'(r_err),  64'(v[i].e_err));
            chk($sformatf("vec%0d_lat", i),  64'(lat),    64'd17);
        end

        // Backpressure: hold out_ready low in DONE with a competing word.
        @(negedge clk);
        out_ready = 1'b0;
        send16(16'h0001, 1'b0, 7'h00, r_crc, r_code, r_err, lat);
        chk("bp_first_crc", 64'(r_crc), 64'h09);
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("bp_valid%0d", i), 64'(out_valid), 64'd1);
            chk($sformatf("bp_crc%0d", i),   64'(out_crc),   64'h09);
            chk($sformatf("bp_code%0d", i),  64'(out_code),  64'h89);
            chk($sformatf("bp_rdy%0d", i),   64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_drain_valid", 64'(out_valid), 64'd0);
        chk("bp_drain_ready", 64'(in_ready),  64'd1);
        chk("bp_drain_busy",  64'(busy),      64'd0);
        chk("bp_drain_crc",   64'(out_crc),   64'h09);

        // Reset pulse mid-SHIFT (counter at 5).
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        in_check = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("mr_in_ready",  64'(in_ready),  64'd1);
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_busy",      64'(busy),      64'd0);
        chk("mr_out_crc",   64'(out_crc),   64'd0);
        chk("mr_out_code",  64'(out_code),  64'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("mr_no_valid", 64'(seen), 64'd0);
        send16(16'h0001, 1'b1, 7'h08, r_crc, r_code, r_err, lat);
        chk("mr_next_crc", 64'(r_crc), 64'h09);
        chk("mr_next_err", 64'(r_err), 64'd1);

        // Back-to-back: in_valid and out_ready held high for 4 words.
        bw[0] = 16'h0001; be[0] = 7'h09;
        bw[1] = 16'h0000; be[1] = 7'h00;
        bw[2] = 16'h8000; be[2] = 7'h53;
        bw[3] = 16'h0003; be[3] = 7'h1B;
        @(negedge clk);
        in_valid = 1'b1;
        in_check = 1'b0;
        in_data  = bw[0];
        for (int i = 0; i < 4; i++) begin
            j = 0;
            while (!in_ready && j < 100) begin
                @(negedge clk);
                j++;
            end
            acc[i] = cyc;
            @(posedge clk);
            @(negedge clk);
            if (i < 3) in_data = bw[i+1];
            else       in_valid = 1'b0;
            j = 0;
            while (!out_valid && j < 100) begin
                @(negedge clk);
                j++;
            end
            chk($sformatf("b2b%0d_crc", i), 64'(out_crc), 64'(be[i]));
            chk($sformatf("b2b%0d_code", i), 64'(out_code),
                {41'd0, bw[i], be[i]});
            @(negedge clk);
            if (i > 0)
                chk($sformatf("b2b%0d_gap", i), 64'(acc[i] - acc[i-1]),
                    64'd18);
        end

        // 40-bit payload instance.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b_valid = 1'b1;
            b_data  = w[i].d;
            @(posedge clk);
            @(negedge clk);
            b_valid = 1'b0;
            j = 0;
            while (!b_ovalid && j < 200) begin
                @(negedge clk);
                j++;
            end
            chk($sformatf("w40_%0d_crc", i), 64'(b_crc), 64'(w[i].e_crc));
            chk($sformatf("w40_%0d_code", i), 64'(b_code),
                {w[i].d, w[i].e_crc});
            chk($sformatf("w40_%0d_lat", i), 64'(j + 1), 64'd41);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
